// File: rtl/refresh_scheduler_if.sv
// Refresh scheduler bus: groups the filter query/verdict handshake, the
// auto-refresh request/grant handshake and the status outputs.
//   master : refresh_scheduler side (drives query, request, status)
//   slave  : filter / command-scheduler side (drives dref, ref_gnt)
// Signals:
//   to_refresh   one-cycle query pulse to the dummy-refresh filter
//   dref         filter verdict, valid the cycle after to_refresh (1 = dummy)
//   ref_row      row group being refreshed
//   ref_req      auto-refresh request
//   ref_urgent   debt at its maximum
//   ref_gnt      command scheduler accepts ref_req
//   ref_busy     tRFC window active
//   dummy_cnt    saturating count of dummy-retired refreshes
//   overflow_err sticky debt-overflow flag
interface refresh_scheduler_if #(
    parameter int ROW_WIDTH = 16
);
    logic                 to_refresh;
    logic                 dref;
    logic [ROW_WIDTH-1:0] ref_row;
    logic                 ref_req;
    logic                 ref_urgent;
    logic                 ref_gnt;
    logic                 ref_busy;
    logic [15:0]          dummy_cnt;
    logic                 overflow_err;

    modport master (
        output to_refresh, ref_row, ref_req, ref_urgent, ref_busy,
               dummy_cnt, overflow_err,
        input  dref, ref_gnt
    );

    modport slave (
        input  to_refresh, ref_row, ref_req, ref_urgent, ref_busy,
               dummy_cnt, overflow_err,
        output dref, ref_gnt
    );
endinterface

// File: rtl/refresh_scheduler.sv
// Refresh-timing stage in front of the write-aware dummy-refresh filter.
// Counts tREFI intervals into a refresh debt, queries the filter for each
// owed refresh, and either retires it as a dummy or requests an auto-refresh
// and holds the tRFC busy window once it is granted.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  refresh_scheduler_if master modport (see interface header)
module refresh_scheduler #(
    parameter int ROW_WIDTH    = 16,
    parameter int T_REFI       = 7800,
    parameter int T_RFC        = 350,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                clk,
    input  logic                rst,
    refresh_scheduler_if.master bus
);
    localparam int DEBT_W = $clog2(MAX_POSTPONE + 1);
    localparam int REFI_W = $clog2(T_REFI);
    localparam int RFC_W  = (T_RFC > 1) ? $clog2(T_RFC) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, PEND, RFC} state_t;

    state_t               state, state_nxt;
    logic [REFI_W-1:0]    refi_cnt;
    logic [RFC_W-1:0]     rfc_cnt;
    logic [DEBT_W-1:0]    debt;
    logic [ROW_WIDTH-1:0] ref_row;
    logic [15:0]          dummy_cnt;
    logic                 overflow_err;
    logic                 tick;
    logic                 retire;
    logic                 dummy_hit;
    logic                 row_adv;
    logic                 rfc_load;
    logic                 to_refresh;
    logic                 ref_req;
    logic                 ref_busy;

    assign tick = (refi_cnt == '0);

    always_comb begin
        state_nxt  = state;
        to_refresh = 1'b0;
        ref_req    = 1'b0;
        ref_busy   = 1'b0;
        retire     = 1'b0;
        dummy_hit  = 1'b0;
        row_adv    = 1'b0;
        rfc_load   = 1'b0;
        case (state)
            IDLE: begin
                if (debt != '0) begin
                    to_refresh = 1'b1;
                    state_nxt  = EVAL;
                end
            end
            EVAL: begin
                if (bus.dref) begin
                    retire    = 1'b1;
                    dummy_hit = 1'b1;
                    row_adv   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                ref_req = 1'b1;
                if (bus.ref_gnt) begin
                    retire    = 1'b1;
                    rfc_load  = 1'b1;
                    state_nxt = RFC;
                end
            end
            RFC: begin
                ref_busy = 1'b1;
                if (rfc_cnt == '0) begin
                    row_adv   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            refi_cnt     <= REFI_W'(T_REFI - 1);
            rfc_cnt      <= '0;
            debt         <= '0;
            ref_row      <= '0;
            dummy_cnt    <= '0;
            overflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            refi_cnt <= tick ? REFI_W'(T_REFI - 1) : refi_cnt - 1'b1;

            // Tick and retire together cancel; a tick at full debt is lost.
            if (tick && !retire) begin
                if (debt == DEBT_W'(MAX_POSTPONE))
                    overflow_err <= 1'b1;
                else
                    debt <= debt + 1'b1;
            end else if (!tick && retire) begin
                debt <= debt - 1'b1;
            end

            if (rfc_load)
                rfc_cnt <= RFC_W'(T_RFC - 1);
            else if (state == RFC && rfc_cnt != '0)
                rfc_cnt <= rfc_cnt - 1'b1;

            if (row_adv)
                ref_row <= ref_row + 1'b1;

            if (dummy_hit && dummy_cnt != 16'hFFFF)
                dummy_cnt <= dummy_cnt + 1'b1;
        end
    end

    assign bus.to_refresh   = to_refresh;
    assign bus.ref_req      = ref_req;
    assign bus.ref_busy     = ref_busy;
    assign bus.ref_row      = ref_row;
    assign bus.ref_urgent   = (debt == DEBT_W'(MAX_POSTPONE));
    assign bus.dummy_cnt    = dummy_cnt;
    assign bus.overflow_err = overflow_err;
endmodule
